// File: rtl/huffman_encoder.sv
`default_nettype none
// ============================================================================
// Module   : huffman_encoder
// Purpose  : Builds a deflate canonical code table from per-symbol lengths and
//            emits each accepted symbol's codeword serially, MSB first.
// Revision : 1.0
// ============================================================================
module huffman_encoder #(
    parameter int NUMCODES = 288,
    parameter int OUTWIDTH = 10,
    parameter int MAXLEN   = 15
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                inew,
    input  logic                ilen_en,
    input  logic [3:0]          ilen,
    input  logic                isym_valid,
    input  logic [OUTWIDTH-1:0] isym,
    output logic                isym_ready,
    output logic                oen,
    output logic                obit,
    output logic                oerr
);
    localparam int                AW       = (NUMCODES > 1) ? $clog2(NUMCODES) : 1;
    localparam int                CW       = $clog2(NUMCODES) + 1;
    localparam logic [AW-1:0]     LAST_IDX = AW'(NUMCODES - 1);
    localparam logic [OUTWIDTH:0] NUM_SYM  = (OUTWIDTH + 1)'(NUMCODES);
    localparam logic [3:0]        LAST_B   = 4'(MAXLEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_NEXTCODE = 3'd2,
        S_ASSIGN   = 3'd3,
        S_READY    = 3'd4,
        S_FETCH    = 3'd5,
        S_SEND     = 3'd6
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     idx_q;
    logic [3:0]        b_q;
    logic [MAXLEN:0]   acc_q;
    logic [CW-1:0]     bl_count_q  [0:MAXLEN];
    logic [MAXLEN:0]   next_code_q [1:MAXLEN];
    logic [3:0]        len_mem     [0:NUMCODES-1];
    logic [MAXLEN-1:0] code_mem    [0:NUMCODES-1];
    logic [3:0]        rd_len_q;
    logic [MAXLEN-1:0] rd_code_q;
    logic [3:0]        cnt_q;
    logic              oen_q;
    logic              obit_q;
    logic              oerr_q;

    logic              sym_ok;
    logic [AW-1:0]     rd_idx;
    logic [3:0]        sel_len;
    logic [MAXLEN-1:0] sel_code;
    logic [3:0]        alen;
    logic [CW-1:0]     bl_prev;
    logic [MAXLEN:0]   acc_sum;
    logic [MAXLEN:0]   acc_d;
    logic              len_we;
    logic              code_we;

    // Out-of-range symbols read entry 0 but are flagged as errors below.
    assign sym_ok   = ({1'b0, isym} < NUM_SYM);
    assign rd_idx   = sym_ok ? AW'(isym) : '0;
    assign sel_len  = len_mem[rd_idx];
    assign sel_code = code_mem[rd_idx];
    assign alen     = len_mem[idx_q];

    assign bl_prev  = (b_q == 4'd1) ? '0 : bl_count_q[b_q - 4'd1];
    assign acc_sum  = acc_q + (MAXLEN + 1)'(bl_prev);
    assign acc_d    = {acc_sum[MAXLEN-1:0], 1'b0};

    assign len_we   = (state_q == S_LOAD) && ilen_en && !inew;
    assign code_we  = (state_q == S_ASSIGN) && (alen != 4'd0) && !inew;

    always_ff @(posedge clk) begin
        if (len_we) begin
            len_mem[idx_q] <= ilen;
        end
        if (code_we) begin
            code_mem[idx_q] <= next_code_q[alen][MAXLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            b_q       <= 4'd1;
            acc_q     <= '0;
            rd_len_q  <= '0;
            rd_code_q <= '0;
            cnt_q     <= '0;
            oen_q     <= 1'b0;
            obit_q    <= 1'b0;
            oerr_q    <= 1'b0;
            for (int i = 0; i <= MAXLEN; i++) bl_count_q[i] <= '0;
            for (int i = 1; i <= MAXLEN; i++) next_code_q[i] <= '0;
        end else if (inew) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            oen_q   <= 1'b0;
            obit_q  <= 1'b0;
            oerr_q  <= 1'b0;
            for (int i = 0; i <= MAXLEN; i++) bl_count_q[i] <= '0;
        end else begin
            oerr_q <= 1'b0;
            case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (ilen_en) begin
                        bl_count_q[ilen] <= bl_count_q[ilen] + CW'(1);
                        idx_q            <= idx_q + AW'(1);
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_NEXTCODE;
                            b_q     <= 4'd1;
                            acc_q   <= '0;
                        end
                    end
                end
                S_NEXTCODE: begin
                    next_code_q[b_q] <= acc_d;
                    acc_q            <= acc_d;
                    if (b_q == LAST_B) begin
                        state_q <= S_ASSIGN;
                        idx_q   <= '0;
                    end else begin
                        b_q <= b_q + 4'd1;
                    end
                end
                S_ASSIGN: begin
                    if (alen != 4'd0) begin
                        next_code_q[alen] <= next_code_q[alen] + (MAXLEN + 1)'(1);
                    end
                    idx_q <= idx_q + AW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    if (isym_valid) begin
                        rd_len_q  <= sym_ok ? sel_len : 4'd0;
                        rd_code_q <= sel_code;
                        oerr_q    <= !sym_ok || (sel_len == 4'd0);
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (rd_len_q == 4'd0) begin
                        state_q <= S_READY;
                    end else begin
                        oen_q   <= 1'b1;
                        obit_q  <= rd_code_q[rd_len_q - 4'd1];
                        cnt_q   <= rd_len_q;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cnt_q == 4'd1) begin
                        oen_q   <= 1'b0;
                        obit_q  <= 1'b0;
                        state_q <= S_READY;
                    end else begin
                        obit_q <= rd_code_q[cnt_q - 4'd2];
                        cnt_q  <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign isym_ready = (state_q == S_READY);
    assign oen        = oen_q;
    assign obit       = obit_q;
    assign oerr       = oerr_q;

endmodule
`default_nettype wire

// File: tb/tb_huffman_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_huffman_encoder
// Purpose  : Directed and randomized stimulus for huffman_encoder, compared
//            every cycle against a canonical-code model.
// Revision : 1.0
// ============================================================================
module tb_huffman_encoder;
    localparam int NUMCODES = 8;
    localparam int OUTWIDTH = 3;
    localparam int MAXLEN   = 15;

    logic                clk        = 1'b0;
    logic                rstn       = 1'b0;
    logic                inew       = 1'b0;
    logic                ilen_en    = 1'b0;
    logic [3:0]          ilen       = 4'd0;
    logic                isym_valid = 1'b0;
    logic [OUTWIDTH-1:0] isym       = '0;
    logic                isym_ready;
    logic                oen;
    logic                obit;
    logic                oerr;

    huffman_encoder #(
        .NUMCODES (NUMCODES),
        .OUTWIDTH (OUTWIDTH),
        .MAXLEN   (MAXLEN)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .inew       (inew),
        .ilen_en    (ilen_en),
        .ilen       (ilen),
        .isym_valid (isym_valid),
        .isym       (isym),
        .isym_ready (isym_ready),
        .oen        (oen),
        .obit       (obit),
        .oerr       (oerr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected outputs for upcoming cycles; empty queue means idle/ready.
    typedef struct packed {
        logic en;
        logic b;
        logic err;
        logic rdy;
    } exp_t;

    exp_t exp_q [$];
    int   m_len  [NUMCODES];
    int   m_code [NUMCODES];
    int   m_idx     = 0;
    bit   m_loading = 1'b0;
    bit   m_ready   = 1'b0;
    logic cap_bits [$];
    int   cap_err   = 0;

    int lens_a   [NUMCODES] = '{3, 3, 3, 3, 3, 2, 4, 4};
    int lens_b   [NUMCODES] = '{2, 2, 0, 2, 2, 0, 0, 0};
    int lens_all3[NUMCODES] = '{3, 3, 3, 3, 3, 3, 3, 3};
    int lens_r   [NUMCODES];

    // Canonical assignment: shortest codes first, ties by symbol order.
    function automatic void build_codes();
        int code = 0;
        for (int b = 1; b <= MAXLEN; b++) begin
            for (int s = 0; s < NUMCODES; s++) begin
                if (m_len[s] == b) begin
                    m_code[s] = code & ((1 << MAXLEN) - 1);
                    code++;
                end
            end
            code = code << 1;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        int   s;
        bit   bad;
        if (!rstn) begin
            exp_q.delete();
            m_loading = 1'b0;
            m_ready   = 1'b0;
            e = '0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '0;
            e.rdy = m_ready;
        end
        n_checks++;
        if ({oen, obit, oerr, isym_ready} !== {e.en, e.b, e.err, e.rdy}) begin
            n_fail++;
            $display("FAIL cycle_outputs @%0d: got oen=%b obit=%b oerr=%b rdy=%b, expected oen=%b obit=%b oerr=%b rdy=%b",
                     cyc, oen, obit, oerr, isym_ready, e.en, e.b, e.err, e.rdy);
        end
        if (oen === 1'b1) cap_bits.push_back(obit);
        if (oerr === 1'b1) cap_err++;
        if (rstn) begin
            if (inew) begin
                exp_q.delete();
                m_loading = 1'b1;
                m_ready   = 1'b0;
                m_idx     = 0;
            end else if (m_loading && ilen_en) begin
                m_len[m_idx] = int'(ilen);
                m_idx++;
                if (m_idx == NUMCODES) begin
                    m_loading = 1'b0;
                    build_codes();
                    repeat (MAXLEN + NUMCODES) exp_q.push_back('0);
                    m_ready = 1'b1;
                end
            end else if (e.rdy && isym_valid) begin
                s   = int'(isym);
                bad = (s >= NUMCODES) || (m_len[s] == 0);
                n = '0;
                n.err = bad;
                exp_q.push_back(n);
                if (!bad) begin
                    for (int i = m_len[s] - 1; i >= 0; i--) begin
                        n = '0;
                        n.en = 1'b1;
                        n.b  = ((m_code[s] >> i) & 1) != 0;
                        exp_q.push_back(n);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [63:0] pack_bits();
        logic [63:0] v = '0;
        foreach (cap_bits[i]) v = {v[62:0], cap_bits[i]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input int lens[NUMCODES], input bit gaps, output int last_cyc);
        inew = 1'b1;
        tick();
        inew = 1'b0;
        for (int s = 0; s < NUMCODES; s++) begin
            if (gaps) begin
                ilen_en = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            ilen_en  = 1'b1;
            ilen     = 4'(lens[s]);
            last_cyc = cyc;
            tick();
        end
        ilen_en = 1'b0;
    endtask

    task automatic wait_ready(output int rc);
        rc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (isym_ready === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: got timeout, expected isym_ready within 2000 cycles");
        end
        tick();
    endtask

    task automatic send_sym(input int s, input bit keep, output int t);
        isym       = OUTWIDTH'(s);
        isym_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (isym_ready === 1'b1) begin
                t = cyc;
                break;
            end
            tick();
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_sym: got no acceptance, expected symbol %0d taken within 200 cycles", s);
        end
        tick();
        if (!keep) isym_valid = 1'b0;
    endtask

    task automatic random_syms(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            send_sym($urandom_range(0, NUMCODES - 1), ($urandom_range(0, 1) == 1), t);
            if (!isym_valid) repeat ($urandom_range(0, 2)) tick();
        end
        isym_valid = 1'b0;
        wait_ready(t);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l;
        int r;
        int t;
        int t2;
        int cnt;

        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        check("reset_outputs", 64'({isym_ready, oen, obit, oerr}), 64'd0);
        repeat (3) tick();

        load_table(lens_a, 1'b0, l);
        wait_ready(r);
        check("ready_latency", 64'(r - l), 64'(MAXLEN + NUMCODES + 1));
        check("model_code_sym0", 64'(m_code[0]), 64'd2);
        check("model_code_sym5", 64'(m_code[5]), 64'd0);
        check("model_code_sym6", 64'(m_code[6]), 64'd14);
        check("model_code_sym7", 64'(m_code[7]), 64'd15);

        cap_bits.delete();
        send_sym(0, 1'b0, t);
        send_sym(5, 1'b0, t);
        send_sym(6, 1'b0, t);
        send_sym(7, 1'b0, t2);
        wait_ready(r);
        check("sym6_reaccept_gap", 64'(t2 - t), 64'd6);
        check("stream_0567_len", 64'(cap_bits.size()), 64'd13);
        check("stream_0567_bits", pack_bits(), 64'b0100011101111);

        cap_bits.delete();
        send_sym(0, 1'b1, t);
        send_sym(1, 1'b1, t);
        send_sym(0, 1'b0, t);
        wait_ready(r);
        check("b2b_len", 64'(cap_bits.size()), 64'd9);
        check("b2b_bits", pack_bits(), 64'b010011010);

        random_syms(40);

        load_table(lens_b, 1'b1, l);
        wait_ready(r);
        cap_bits.delete();
        cap_err = 0;
        send_sym(2, 1'b0, t);
        send_sym(3, 1'b0, t2);
        wait_ready(r);
        check("zero_len_err_pulses", 64'(cap_err), 64'd1);
        check("zero_len_reaccept", 64'(t2 - t), 64'd2);
        check("after_err_bits", pack_bits(), 64'b10);
        check("after_err_len", 64'(cap_bits.size()), 64'd2);

        load_table(lens_a, 1'b0, l);
        wait_ready(r);
        cap_bits.delete();
        send_sym(6, 1'b0, t);
        tick();
        tick();
        load_table(lens_all3, 1'b0, l);
        check("abort_bits_len", 64'(cap_bits.size()), 64'd2);
        check("abort_bits", pack_bits(), 64'b11);
        wait_ready(r);
        cap_bits.delete();
        send_sym(7, 1'b0, t);
        wait_ready(r);
        check("reload_sym7_bits", pack_bits(), 64'b111);
        check("reload_sym7_len", 64'(cap_bits.size()), 64'd3);

        foreach (lens_r[i]) lens_r[i] = $urandom_range(0, 5);
        load_table(lens_r, 1'b0, l);
        while (cyc < l + MAXLEN + 3) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        isym_valid = 1'b1;
        isym = '0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (isym_ready !== 1'b0) cnt++;
            tick();
        end
        isym_valid = 1'b0;
        check("ready_after_reset_in_assign", 64'(cnt), 64'd0);

        for (int k = 0; k < 4; k++) begin
            foreach (lens_r[i]) lens_r[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            load_table(lens_r, 1'b1, l);
            wait_ready(r);
            random_syms(25);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
